pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match flow controller: serve countdown, scoring, game over.
// Optional PONG_PAUSE_EN adds a PAUSE state toggled by the start button during play.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_reset,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               start_q;
  logic               start_rise;

  // start_q resets high so a button held through reset cannot fire until released
  assign start_rise = start_btn & ~start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      score_left_q  <= '0;
      score_right_q <= '0;
      winner_q      <= 2'b00;
      serve_dir_q   <= 1'b1;
      start_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      start_q       <= start_btn;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          cnt_d   = CNT_LOAD;
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // a simultaneous double miss is a let: no point, just re-serve
        if (miss_left && miss_right) begin
          cnt_d   = CNT_LOAD;
          state_d = S_SERVE;
        end else if (miss_left) begin
          if (score_right_q != WIN_VAL) score_right_d = score_right_q + SCORE_ONE;
          serve_dir_d = 1'b0;
          state_d     = S_POINT;
        end else if (miss_right) begin
          if (score_left_q != WIN_VAL) score_left_d = score_left_q + SCORE_ONE;
          serve_dir_d = 1'b1;
          state_d     = S_POINT;
        end
`ifdef PONG_PAUSE_EN
        else if (start_rise) begin
          state_d = S_PAUSE;
        end
`endif
      end
      S_POINT: begin
        if (score_left_q == WIN_VAL) begin
          winner_d = 2'b01;
          state_d  = S_OVER;
        end else if (score_right_q == WIN_VAL) begin
          winner_d = 2'b10;
          state_d  = S_OVER;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (start_rise) begin
          score_left_d  = '0;
          score_right_d = '0;
          winner_d      = 2'b00;
          serve_dir_d   = 1'b1;
          cnt_d         = CNT_LOAD;
          state_d       = S_SERVE;
        end
      end
`ifdef PONG_PAUSE_EN
      S_PAUSE: begin
        if (start_rise) state_d = S_PLAY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ball_reset = 1'b1;
    ball_run   = 1'b0;
    case (state_q)
      S_PLAY: begin
        ball_reset = 1'b0;
        ball_run   = 1'b1;
      end
`ifdef PONG_PAUSE_EN
      S_PAUSE: ball_reset = 1'b0;
`endif
      default: begin
        ball_reset = 1'b1;
        ball_run   = 1'b0;
      end
    endcase
  end

  assign serve_dir   = serve_dir_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign winner      = winner_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - vector table, directed corner sequences and randomized model check for pong_game_ctrl.
module tb_pong_game_ctrl;
  localparam int WIN = 3;
  localparam int SD  = 3;
  localparam int SW  = 4;
`ifdef PONG_PAUSE_EN
  localparam int PST = 5;
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam int PST = 2;
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0;
  logic          start_btn = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic          ball_reset, ball_run, serve_dir;
  logic [SW-1:0] score_left, score_right;
  logic [1:0]    winner;
  logic [2:0]    game_state;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_reset(ball_reset), .ball_run(ball_run), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right),
    .winner(winner), .game_state(game_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit r, s, t, l, m;
    int st, sl, sr, w, sd;
  } vec_t;
  vec_t vecs[$];

  // behavioural model: game phase, ticks still owed in the serve countdown, tallies
  int m_st, m_ticks, m_sl, m_sr, m_w, m_sd;
  bit m_prev_btn;

  function automatic vec_t v(bit r, bit s, bit t, bit l, bit m, int st, int sl, int sr, int w, int sd);
    vec_t x;
    x.r = r; x.s = s; x.t = t; x.l = l; x.m = m;
    x.st = st; x.sl = sl; x.sr = sr; x.w = w; x.sd = sd;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input int st, input int sl, input int sr, input int w, input int sd);
    chk({tag, " state"}, 32'(game_state), st);
    chk({tag, " score_left"}, 32'(score_left), sl);
    chk({tag, " score_right"}, 32'(score_right), sr);
    chk({tag, " winner"}, 32'(winner), w);
    chk({tag, " serve_dir"}, 32'(serve_dir), sd);
    chk({tag, " ball_run"}, 32'(ball_run), (st == 2) ? 1 : 0);
    chk({tag, " ball_reset"}, 32'(ball_reset), (st == 2 || st == 5) ? 0 : 1);
  endtask

  task automatic step(input bit r, input bit s, input bit t, input bit l, input bit m);
    rst = r; start_btn = s; frame_tick = t; miss_left = l; miss_right = m;
    @(posedge clk);
    #1;
  endtask

  task automatic run_serve();
    for (int i = 0; i < SD; i++) step(0, 0, 1, 0, 0);
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input bit l, input bit m);
    bit rise;
    if (r) begin
      m_st = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_w = 0; m_sd = 1; m_prev_btn = 1;
      return;
    end
    rise = s && !m_prev_btn;
    m_prev_btn = s;
    if (m_st == 0) begin
      if (rise) begin m_st = 1; m_ticks = SD; end
    end else if (m_st == 1) begin
      if (t) begin
        m_ticks = m_ticks - 1;
        if (m_ticks == 0) m_st = 2;
      end
    end else if (m_st == 2) begin
      if (l && m) begin m_st = 1; m_ticks = SD; end
      else if (l) begin m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_sd = 0; m_st = 3; end
      else if (m) begin m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_sd = 1; m_st = 3; end
      else if (PAUSE_EN && rise) m_st = 5;
    end else if (m_st == 3) begin
      if (m_sl == WIN) begin m_w = 1; m_st = 4; end
      else if (m_sr == WIN) begin m_w = 2; m_st = 4; end
      else begin m_st = 1; m_ticks = SD; end
    end else if (m_st == 4) begin
      if (rise) begin m_sl = 0; m_sr = 0; m_w = 0; m_sd = 1; m_st = 1; m_ticks = SD; end
    end else if (m_st == 5) begin
      if (rise) m_st = 2;
    end
  endtask

  initial begin
    // r s t l m | state sl sr win sd
    vecs.push_back(v(1,0,0,0,0, 0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,1));
    vecs.push_back(v(0,1,0,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,0,1,0,0, 2,0,0,0,1));
    vecs.push_back(v(0,0,0,1,0, 3,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 2,0,1,0,0));
    vecs.push_back(v(0,0,0,1,1, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 1,0,1,0,0));
    vecs.push_back(v(0,0,1,0,0, 2,0,1,0,0));
    vecs.push_back(v(0,0,0,0,1, 3,1,1,0,1));
    vecs.push_back(v(0,0,0,0,0, 1,1,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,1,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,1,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 2,1,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 3,2,1,0,1));
    vecs.push_back(v(0,0,0,0,0, 1,2,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,2,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 1,2,1,0,1));
    vecs.push_back(v(0,0,1,0,0, 2,2,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 3,3,1,0,1));
    vecs.push_back(v(0,0,0,0,1, 4,3,1,1,1));
    vecs.push_back(v(0,0,0,1,0, 4,3,1,1,1));
    vecs.push_back(v(0,1,0,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0, 1,0,0,0,1));
    vecs.push_back(v(0,1,0,0,0, 1,0,0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].l, vecs[i].m);
      expect_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].sl, vecs[i].sr, vecs[i].w, vecs[i].sd);
    end

    // reach PLAY at 2/1, then reset mid-play
    run_serve();
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); run_serve();
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); run_serve();
    step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); run_serve();
    expect_all("pre_rst", 2, 2, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    expect_all("mid_rst", 0, 0, 0, 0, 1);

    // button held through reset must not start a game
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0);
      expect_all($sformatf("held%0d", i), 0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0);
    expect_all("released", 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_all("repress", 1, 0, 0, 0, 1);

    // start edge during play: pause or ignored depending on build
    run_serve();
    expect_all("pre_pause", 2, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    expect_all("pause_edge", PST, 0, 0, 0, 1);
`ifdef PONG_PAUSE_EN
    step(0, 0, 1, 1, 0);
    expect_all("pause_miss", 5, 0, 0, 0, 1);
`else
    step(0, 0, 0, 0, 0);
    expect_all("pause_rel", 2, 0, 0, 0, 1);
`endif
    step(0, 1, 0, 0, 0);
    expect_all("unpause", 2, 0, 0, 0, 1);

    // randomized run against the model
    step(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, s, t, l, m;
      r = ($urandom_range(0, 299) == 0);
      s = start_btn ^ ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 7) == 0);
      m = ($urandom_range(0, 7) == 0);
      step(r, s, t, l, m);
      model_step(r, s, t, l, m);
      expect_all($sformatf("rand%0d", i), m_st, m_sl, m_sr, m_w, m_sd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
